// File: rtl/seg7_scan_decoder_if.sv
// Display-loopback bus between a scanned 4-digit 7-segment display and its decoder.
//   seg_in      : segment bus, active-low, {a,b,c,d,e,f,g,dp}
//   dig_sel_n   : digit selects, active-low, bit i = digit i
//   hex_out     : recovered nibble of digit i on [4i+3:4i]
//   dp_out      : decimal point lit per digit
//   digit_err   : last capture of digit i matched no hex code
//   frame_valid : sticky, all four digits captured at least once
//   frame_done  : one-cycle pulse per completed frame
// master = display side (drives the bus), slave = decoder.
interface seg7_scan_decoder_if;
  logic [7:0]  seg_in;
  logic [3:0]  dig_sel_n;
  logic [15:0] hex_out;
  logic [3:0]  dp_out;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        frame_done;

  modport master (
    output seg_in,
    output dig_sel_n,
    input  hex_out,
    input  dp_out,
    input  digit_err,
    input  frame_valid,
    input  frame_done
  );

  modport slave (
    input  seg_in,
    input  dig_sel_n,
    output hex_out,
    output dp_out,
    output digit_err,
    output frame_valid,
    output frame_done
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Samples a scanned, multiplexed 4-digit 7-segment bus and recovers each digit's hex
// nibble, decimal point and code validity once the bus has been stable for
// STABLE_CYCLES synchronized samples.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   disp : slave side of seg7_scan_decoder_if (bus in, decoded digits out)
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst,
  seg7_scan_decoder_if.slave  disp
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

  logic [7:0]  seg_s1_q, seg_s2_q, seg_p_q;
  logic [3:0]  dig_s1_q, dig_s2_q, dig_p_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] hex_q, hex_d;
  logic [3:0]  dp_q, dp_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  seen_q, seen_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic        same;
  logic        capture;
  logic [3:0]  sel;
  logic        sel_onehot;
  logic [1:0]  idx;
  logic [4:0]  dec;

  // Returns {match, nibble}; dp is not part of the pattern.
  function automatic logic [4:0] decode(input logic [6:0] segs);
    case (segs)
      7'b0000001: decode = {1'b1, 4'h0};
      7'b1001111: decode = {1'b1, 4'h1};
      7'b0010010: decode = {1'b1, 4'h2};
      7'b0000110: decode = {1'b1, 4'h3};
      7'b1001100: decode = {1'b1, 4'h4};
      7'b0100100: decode = {1'b1, 4'h5};
      7'b0100000: decode = {1'b1, 4'h6};
      7'b0001111: decode = {1'b1, 4'h7};
      7'b0000000: decode = {1'b1, 4'h8};
      7'b0000100: decode = {1'b1, 4'h9};
      7'b0001000: decode = {1'b1, 4'hA};
      7'b1100000: decode = {1'b1, 4'hB};
      7'b1110010: decode = {1'b1, 4'hC};
      7'b1000010: decode = {1'b1, 4'hD};
      7'b0110000: decode = {1'b1, 4'hE};
      7'b0111000: decode = {1'b1, 4'hF};
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  // Two-flop synchronizers plus the previous-sample register; reset to blank/no digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1_q <= 8'hFF;
      seg_s2_q <= 8'hFF;
      seg_p_q  <= 8'hFF;
      dig_s1_q <= 4'hF;
      dig_s2_q <= 4'hF;
      dig_p_q  <= 4'hF;
    end else begin
      seg_s1_q <= disp.seg_in;
      seg_s2_q <= seg_s1_q;
      seg_p_q  <= seg_s2_q;
      dig_s1_q <= disp.dig_sel_n;
      dig_s2_q <= dig_s1_q;
      dig_p_q  <= dig_s2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      hex_q   <= 16'h0000;
      dp_q    <= 4'h0;
      err_q   <= 4'h0;
      seen_q  <= 4'h0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      dp_q    <= dp_d;
      err_q   <= err_d;
      seen_q  <= seen_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    same = (seg_s2_q == seg_p_q) && (dig_s2_q == dig_p_q);
    // Fires only on the S-1 -> S step, so a saturated counter never recaptures.
    capture = same && (cnt_q == StableCnt - 8'd1);

    sel        = ~dig_s2_q;
    sel_onehot = (sel != 4'h0) && ((sel & (sel - 4'd1)) == 4'h0);
    idx        = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) idx = 2'(i);
    end
    dec = decode(seg_s2_q[7:1]);

    cnt_d = cnt_q;
    if (!same) begin
      cnt_d = 8'd0;
    end else if (cnt_q < StableCnt) begin
      cnt_d = cnt_q + 8'd1;
    end

    hex_d   = hex_q;
    dp_d    = dp_q;
    err_d   = err_q;
    // A full mask reports the frame one edge later and restarts collection.
    done_d  = (seen_q == 4'hF);
    valid_d = valid_q | done_d;
    seen_d  = done_d ? 4'h0 : seen_q;

    if (capture && sel_onehot) begin
      hex_d[{idx, 2'b00} +: 4] = dec[4] ? dec[3:0] : 4'h0;
      err_d[idx]  = ~dec[4];
      dp_d[idx]   = ~seg_s2_q[0];
      seen_d[idx] = 1'b1;
    end
  end

  assign disp.hex_out     = hex_q;
  assign disp.dp_out      = dp_q;
  assign disp.digit_err   = err_q;
  assign disp.frame_valid = valid_q;
  assign disp.frame_done  = done_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: a sample-stream model (run length of
// identical bus samples, delayed by the synchronizer depth) is compared every cycle,
// and directed scenarios pin the model with hand-computed literals.
module tb_seg7_scan_decoder;
  localparam int unsigned S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_decoder_if disp ();

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (disp)
  );

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [6:0]  codes [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b1110010, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [11:0] m_new, m_old, m_last;
  int          m_run;
  logic [15:0] m_hex;
  logic [3:0]  m_dp, m_err, m_seen;
  logic        m_valid, m_done;

  task automatic model_reset();
    m_new = 12'hFFF; m_old = 12'hFFF; m_last = 12'hFFF; m_run = 1;
    m_hex = 16'h0; m_dp = 4'h0; m_err = 4'h0; m_seen = 4'h0;
    m_valid = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step();
    logic [11:0] v;
    logic [3:0]  sel;
    int          idx;
    int          code;
    v = m_old;
    m_old = m_new;
    m_new = {disp.dig_sel_n, disp.seg_in};
    if (v == m_last) begin
      if (m_run < 100000) m_run++;
    end else begin
      m_run = 1;
    end
    m_last = v;
    m_done = (m_seen == 4'hF);
    if (m_done) begin
      m_valid = 1'b1;
      m_seen  = 4'h0;
    end
    sel = ~v[11:8];
    if (m_run == int'(S) + 1 && $countones(sel) == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (sel[i]) idx = i;
      code = -1;
      for (int c = 0; c < 16; c++) if (codes[c] == v[7:1]) code = c;
      m_hex[idx*4 +: 4] = (code >= 0) ? 4'(code) : 4'h0;
      m_err[idx]  = (code < 0);
      m_dp[idx]   = ~v[0];
      m_seen[idx] = 1'b1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle compare and frame_done pulse counter, away from the active edge.
  always @(negedge clk) begin
    check("cycle_outputs",
          {6'b0, disp.hex_out, disp.dp_out, disp.digit_err, disp.frame_valid, disp.frame_done},
          {6'b0, m_hex, m_dp, m_err, m_valid, m_done});
    if (disp.frame_done === 1'b1) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] sel, input logic [7:0] seg);
    @(posedge clk);
    #2;
    disp.dig_sel_n = sel;
    disp.seg_in    = seg;
  endtask

  // Next posedge after the drive is edge 0; returns #1 after edge n-1.
  task automatic hold(input logic [3:0] sel, input logic [7:0] seg, input int n);
    drive(sel, seg);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int prev;

  initial begin
    rst = 1'b1;
    disp.dig_sel_n = 4'hF;
    disp.seg_in    = 8'hFF;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_hex", 32'(disp.hex_out), 32'h0);
    check("reset_dp", 32'(disp.dp_out), 32'h0);
    check("reset_err", 32'(disp.digit_err), 32'h0);
    check("reset_valid", 32'(disp.frame_valid), 32'h0);
    check("reset_done", 32'(disp.frame_done), 32'h0);

    // Digit 0 shows "2": not visible at edge 5, visible at edge 6.
    done_cnt = 0;
    hold(4'b1110, 8'b00100101, 6);
    check("lat_edge5_hex", 32'(disp.hex_out), 32'h0);
    edges(1);
    check("lat_edge6_hex", 32'(disp.hex_out), 32'h0002);
    check("lat_edge6_dp", 32'(disp.dp_out), 32'h0);
    check("lat_edge6_err", 32'(disp.digit_err), 32'h0);
    edges(13);
    check("lat_no_done", 32'(done_cnt), 32'd0);

    // Full scan 2,A,F,8 with dp lit on digit 3.
    done_cnt = 0;
    hold(4'b1110, 8'b00100101, 20);
    hold(4'b1101, 8'b00010001, 20);
    hold(4'b1011, 8'b01110001, 20);
    hold(4'b0111, 8'b00000000, 20);
    check("scan_hex", 32'(disp.hex_out), 32'h8FA2);
    check("scan_dp", 32'(disp.dp_out), 32'b1000);
    check("scan_err", 32'(disp.digit_err), 32'h0);
    check("scan_valid", 32'(disp.frame_valid), 32'h1);
    check("scan_done_pulses", 32'(done_cnt), 32'd1);

    // Blank pattern on digit 1.
    hold(4'b1101, 8'hFF, 20);
    check("blank_err", 32'(disp.digit_err), 32'b0010);
    check("blank_hex", 32'(disp.hex_out), 32'h8F02);
    check("blank_dp", 32'(disp.dp_out), 32'b1000);

    // Digit 2 toggling every 3 cycles between "3" and "5", then held on "5".
    prev = done_cnt;
    for (int k = 0; k < 8; k++) hold(4'b1011, (k % 2 == 1) ? 8'b01001001 : 8'b00001101, 3);
    check("glitch_hex", 32'(disp.hex_out), 32'h8F02);
    check("glitch_err", 32'(disp.digit_err), 32'b0010);
    check("glitch_no_done", 32'(done_cnt), 32'(prev));
    edges(3);
    check("glitch_edge5_hex", 32'(disp.hex_out), 32'h8F02);
    edges(1);
    check("glitch_edge6_hex", 32'(disp.hex_out), 32'h8502);
    edges(14);

    // Two digits selected, then none: ignored entirely.
    prev = done_cnt;
    hold(4'b1100, 8'b00000011, 20);
    hold(4'b1111, 8'b00000011, 20);
    check("badsel_hex", 32'(disp.hex_out), 32'h8502);
    check("badsel_err", 32'(disp.digit_err), 32'b0010);
    check("badsel_dp", 32'(disp.dp_out), 32'b1000);
    hold(4'b1110, 8'b10011111, 20);
    hold(4'b1101, 8'b00001101, 20);
    hold(4'b1011, 8'b00011111, 20);
    check("badsel_partial_no_done", 32'(done_cnt), 32'(prev));
    hold(4'b0111, 8'b11100101, 20);
    check("badsel_frame_done", 32'(done_cnt), 32'(prev + 1));
    check("badsel_scan_hex", 32'(disp.hex_out), 32'hC731);

    // Reset with three digits seen and digit 3 qualifying.
    hold(4'b1110, 8'b00001001, 20);
    hold(4'b1101, 8'b11000001, 20);
    hold(4'b1011, 8'b10000101, 20);
    drive(4'b0111, 8'b01100001);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_hex", 32'(disp.hex_out), 32'h0);
    check("rst_mid_dp", 32'(disp.dp_out), 32'h0);
    check("rst_mid_err", 32'(disp.digit_err), 32'h0);
    check("rst_mid_valid", 32'(disp.frame_valid), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    done_cnt = 0;
    edges(20);
    check("rst_after_no_done", 32'(done_cnt), 32'd0);
    check("rst_after_valid", 32'(disp.frame_valid), 32'h0);
    check("rst_after_hex", 32'(disp.hex_out), 32'hE000);
    check("rst_after_err", 32'(disp.digit_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
